ip_sram_model_3w2r: RTL and testbench

Behavioral physical-memory responder for the 2r3w smurf macro: sits on the t1 bank interface and services three write ports (A, B, C) and two read ports (D, E) issued by the 2r3w controller. It holds the array, applies per-bit write enables with fixed port priority, and returns read data after SRAM_DELAY cycles. A post-reset init sequencer zero-fills the array before accepting traffic, so the formal and simulation benches see a defined memory.

---
 rtl/ip_sram_model_3w2r_if.sv | 44 ++++
 rtl/ip_sram_model_3w2r.sv | 187 ++++++++++++++++++
 tb/tb_ip_sram_model_3w2r.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_sram_model_3w2r_if.sv
// t1 bank interface between the 2r3w controller (master) and the memory responder (slave).
interface ip_sram_model_3w2r_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned BITADDR = 10
);
    logic               t1_writeA;
    logic               t1_writeB;
    logic               t1_writeC;
    logic [BITADDR-1:0] t1_addrA;
    logic [BITADDR-1:0] t1_addrB;
    logic [BITADDR-1:0] t1_addrC;
    logic [WIDTH-1:0]   t1_dinA;
    logic [WIDTH-1:0]   t1_dinB;
    logic [WIDTH-1:0]   t1_dinC;
    logic [WIDTH-1:0]   t1_bwA;
    logic [WIDTH-1:0]   t1_bwB;
    logic [WIDTH-1:0]   t1_bwC;
    logic               t1_readD;
    logic               t1_readE;
    logic [BITADDR-1:0] t1_addrD;
    logic [BITADDR-1:0] t1_addrE;
    logic [WIDTH-1:0]   t1_doutD;
    logic [WIDTH-1:0]   t1_doutE;
    logic               t1_vldD;
    logic               t1_vldE;

    modport master (
        output t1_writeA, t1_writeB, t1_writeC,
        output t1_addrA, t1_addrB, t1_addrC,
        output t1_dinA, t1_dinB, t1_dinC,
        output t1_bwA, t1_bwB, t1_bwC,
        output t1_readD, t1_readE, t1_addrD, t1_addrE,
        input  t1_doutD, t1_doutE, t1_vldD, t1_vldE
    );

    modport slave (
        input  t1_writeA, t1_writeB, t1_writeC,
        input  t1_addrA, t1_addrB, t1_addrC,
        input  t1_dinA, t1_dinB, t1_dinC,
        input  t1_bwA, t1_bwB, t1_bwC,
        input  t1_readD, t1_readE, t1_addrD, t1_addrE,
        output t1_doutD, t1_doutE, t1_vldD, t1_vldE
    );
endinterface

// File: rtl/ip_sram_model_3w2r.sv
// Behavioural 3-write / 2-read SRAM responder with post-reset zero-fill and read latency pipe.
module ip_sram_model_3w2r #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUMADDR    = 1024,
    parameter int unsigned BITADDR    = 10,
    parameter int unsigned SRAM_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ip_sram_model_3w2r_if.slave  bus,
    output logic                 init_done,
    output logic                 err
);
    localparam int unsigned AW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state, state_nxt;
    logic [AW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   mem [NUMADDR];

    logic [2:0]         wr, wok, wen;
    logic [BITADDR-1:0] waddr [3];
    logic [WIDTH-1:0]   din [3];
    logic [WIDTH-1:0]   bw [3];
    logic [WIDTH-1:0]   merged [3];
    logic [1:0]         rd, rok, rd_en;
    logic [BITADDR-1:0] raddr [2];
    logic [WIDTH-1:0]   rdata [2];
    logic               run, err_set;

    assign wr       = {bus.t1_writeC, bus.t1_writeB, bus.t1_writeA};
    assign waddr[0] = bus.t1_addrA;
    assign waddr[1] = bus.t1_addrB;
    assign waddr[2] = bus.t1_addrC;
    assign din[0]   = bus.t1_dinA;
    assign din[1]   = bus.t1_dinB;
    assign din[2]   = bus.t1_dinC;
    assign bw[0]    = bus.t1_bwA;
    assign bw[1]    = bus.t1_bwB;
    assign bw[2]    = bus.t1_bwC;
    assign rd       = {bus.t1_readE, bus.t1_readD};
    assign raddr[0] = bus.t1_addrD;
    assign raddr[1] = bus.t1_addrE;

    assign run       = (state == RUN);
    assign init_done = run;

    // state register and zero-fill counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next state: step through every word once, then serve traffic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(NUMADDR - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    // address qualification, read-first array sampling and error detection
    always_comb begin
        wok     = '0;
        wen     = '0;
        rok     = '0;
        rd_en   = '0;
        rdata   = '{default: '0};
        for (int p = 0; p < 3; p++) begin
            wok[p] = (32'(waddr[p]) < NUMADDR);
            wen[p] = wr[p] & wok[p] & run;
        end
        for (int r = 0; r < 2; r++) begin
            rok[r]   = (32'(raddr[r]) < NUMADDR);
            rd_en[r] = rd[r] & run & rst;
            rdata[r] = rok[r] ? mem[AW'(raddr[r])] : '0;
        end
        err_set = run ? ((|(wr & ~wok)) | (|(rd & ~rok))) : ((|wr) | (|rd));
    end

    // per-port merged word: every port hitting the same address is folded in A, B, C order
    always_comb begin
        merged = '{default: '0};
        for (int p = 0; p < 3; p++) begin
            merged[p] = mem[AW'(waddr[p])];
            for (int q = 0; q < 3; q++) begin
                if (wen[q] && (waddr[q] == waddr[p])) begin
                    merged[p] = (merged[p] & ~bw[q]) | (din[q] & bw[q]);
                end
            end
        end
    end

    // array update: zero-fill during INIT, merged writes in RUN
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (wen[p]) begin
                    mem[AW'(waddr[p])] <= merged[p];
                end
            end
        end
    end

    // sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    generate
        if (SRAM_DELAY == 0) begin : g_comb
            logic [WIDTH-1:0] hold [2];

            // remember the last returned word so dout holds between reads
            always_ff @(posedge clk) begin
                if (!rst) begin
                    hold[0] <= '0;
                    hold[1] <= '0;
                end else begin
                    for (int r = 0; r < 2; r++) begin
                        if (rd_en[r]) begin
                            hold[r] <= rdata[r];
                        end
                    end
                end
            end

            assign bus.t1_doutD = rd_en[0] ? rdata[0] : hold[0];
            assign bus.t1_doutE = rd_en[1] ? rdata[1] : hold[1];
            assign bus.t1_vldD  = rd_en[0];
            assign bus.t1_vldE  = rd_en[1];
        end else begin : g_pipe
            logic [WIDTH-1:0] pdata [2][SRAM_DELAY];
            logic             pvld  [2][SRAM_DELAY];

            // read latency pipe; data only advances with its valid so the last stage holds
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int r = 0; r < 2; r++) begin
                        for (int k = 0; k < SRAM_DELAY; k++) begin
                            pvld[r][k]  <= 1'b0;
                            pdata[r][k] <= '0;
                        end
                    end
                end else begin
                    for (int r = 0; r < 2; r++) begin
                        pvld[r][0] <= rd_en[r];
                        if (rd_en[r]) begin
                            pdata[r][0] <= rdata[r];
                        end
                        for (int k = 1; k < SRAM_DELAY; k++) begin
                            pvld[r][k] <= pvld[r][k-1];
                            if (pvld[r][k-1]) begin
                                pdata[r][k] <= pdata[r][k-1];
                            end
                        end
                    end
                end
            end

            assign bus.t1_doutD = pdata[0][SRAM_DELAY-1];
            assign bus.t1_doutE = pdata[1][SRAM_DELAY-1];
            assign bus.t1_vldD  = pvld[0][SRAM_DELAY-1];
            assign bus.t1_vldE  = pvld[1][SRAM_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_ip_sram_model_3w2r.sv
// Bench for ip_sram_model_3w2r: directed scenarios plus random traffic against an array/queue model.
module tb_ip_sram_model_3w2r;
    localparam int unsigned W   = 16;
    localparam int unsigned NA  = 1024;
    localparam int unsigned BA  = 11;
    localparam int unsigned DLY = 2;

    logic clk;
    logic rst;
    logic init_done;
    logic err;

    ip_sram_model_3w2r_if #(.WIDTH(W), .BITADDR(BA)) bus ();

    ip_sram_model_3w2r #(
        .WIDTH(W), .NUMADDR(NA), .BITADDR(BA), .SRAM_DELAY(DLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .init_done(init_done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } rd_t;

    rd_t          qd[$];
    rd_t          qe[$];
    logic [W-1:0] m_mem [NA];
    logic [W-1:0] last_d;
    logic [W-1:0] last_e;
    int           init_left;
    bit           m_err;
    int           cyc;
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle();
        bus.t1_writeA = 1'b0; bus.t1_addrA = '0; bus.t1_dinA = '0; bus.t1_bwA = '0;
        bus.t1_writeB = 1'b0; bus.t1_addrB = '0; bus.t1_dinB = '0; bus.t1_bwB = '0;
        bus.t1_writeC = 1'b0; bus.t1_addrC = '0; bus.t1_dinC = '0; bus.t1_bwC = '0;
        bus.t1_readD  = 1'b0; bus.t1_addrD = '0;
        bus.t1_readE  = 1'b0; bus.t1_addrE = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d, input logic [W-1:0] m);
        case (p)
            0:       begin bus.t1_writeA = 1'b1; bus.t1_addrA = BA'(a); bus.t1_dinA = d; bus.t1_bwA = m; end
            1:       begin bus.t1_writeB = 1'b1; bus.t1_addrB = BA'(a); bus.t1_dinB = d; bus.t1_bwB = m; end
            default: begin bus.t1_writeC = 1'b1; bus.t1_addrC = BA'(a); bus.t1_dinC = d; bus.t1_bwC = m; end
        endcase
    endtask

    task automatic rd(input int p, input int a);
        if (p == 0) begin bus.t1_readD = 1'b1; bus.t1_addrD = BA'(a); end
        else        begin bus.t1_readE = 1'b1; bus.t1_addrE = BA'(a); end
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(NA, (1 << BA) - 1));
        return int'($urandom_range(0, 31));
    endfunction

    // one clock: model consumes the stimulus seen at the edge, outputs checked at the falling edge
    task automatic step();
        bit           r_n;
        bit           we [3];
        int           wa [3];
        logic [W-1:0] wd [3];
        logic [W-1:0] wm [3];
        bit           re [2];
        int           ra [2];
        rd_t          e;
        bit           ev;

        r_n   = rst;
        we[0] = bus.t1_writeA; wa[0] = int'(bus.t1_addrA); wd[0] = bus.t1_dinA; wm[0] = bus.t1_bwA;
        we[1] = bus.t1_writeB; wa[1] = int'(bus.t1_addrB); wd[1] = bus.t1_dinB; wm[1] = bus.t1_bwB;
        we[2] = bus.t1_writeC; wa[2] = int'(bus.t1_addrC); wd[2] = bus.t1_dinC; wm[2] = bus.t1_bwC;
        re[0] = bus.t1_readD;  ra[0] = int'(bus.t1_addrD);
        re[1] = bus.t1_readE;  ra[1] = int'(bus.t1_addrE);

        @(posedge clk);
        cyc++;
        if (!r_n) begin
            init_left = NA;
            m_err     = 1'b0;
            qd.delete();
            qe.delete();
            last_d = '0;
            last_e = '0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (init_left > 0) begin
            if (we[0] || we[1] || we[2] || re[0] || re[1]) m_err = 1'b1;
            init_left--;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (re[r]) begin
                    e.due = cyc + DLY - 1;
                    if (ra[r] < NA) e.data = m_mem[ra[r]];
                    else begin e.data = '0; m_err = 1'b1; end
                    if (r == 0) qd.push_back(e);
                    else        qe.push_back(e);
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (we[p]) begin
                    if (wa[p] < NA) m_mem[wa[p]] = (m_mem[wa[p]] & ~wm[p]) | (wd[p] & wm[p]);
                    else            m_err = 1'b1;
                end
            end
        end

        @(negedge clk);
        ev = (qd.size() > 0) && (qd[0].due == cyc);
        if (ev) begin last_d = qd[0].data; void'(qd.pop_front()); end
        check("vldD", 32'(bus.t1_vldD), 32'(ev));
        check("doutD", 32'(bus.t1_doutD), 32'(last_d));
        ev = (qe.size() > 0) && (qe[0].due == cyc);
        if (ev) begin last_e = qe[0].data; void'(qe.pop_front()); end
        check("vldE", 32'(bus.t1_vldE), 32'(ev));
        check("doutE", 32'(bus.t1_doutE), 32'(last_e));
        check("init_done", 32'(init_done), 32'(init_left == 0));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic wait_init(input int start);
        int n;
        n = start;
        while (init_done !== 1'b1 && n < 3 * NA) begin
            step();
            n++;
        end
        check("init_len", 32'(n), 32'(NA));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        init_left = NA;
        m_err     = 1'b0;
        last_d    = '0;
        last_e    = '0;

        // reset, then a read during zero-fill must be ignored and flag err
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
        rd(0, 5);
        step();
        idle();
        check("init_rd_err", 32'(err), 32'd1);
        step();
        check("init_rd_novld", 32'(bus.t1_vldD), 32'd0);
        wait_init(2);

        // reset clears err and restarts zero-fill
        rst = 1'b0;
        step();
        step();
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        rst = 1'b1;
        wait_init(0);

        // read of a zero-filled word
        rd(0, 5);
        step();
        idle();
        step();
        check("rd5_vld", 32'(bus.t1_vldD), 32'd1);
        check("rd5_data", 32'(bus.t1_doutD), 32'd0);

        // three ports on one address: C beats B beats A bit by bit
        wr(0, 7, 16'hFFFF, 16'hFFFF);
        wr(1, 7, 16'h0000, 16'h00FF);
        wr(2, 7, 16'hAAAA, 16'h000F);
        step();
        idle();
        rd(0, 7);
        step();
        idle();
        step();
        check("merge", 32'(bus.t1_doutD), 32'h0000FF0A);

        // read-first on a same-cycle write, new value on the next read
        wr(0, 3, 16'h1234, 16'hFFFF);
        rd(0, 3);
        step();
        idle();
        rd(1, 3);
        step();
        idle();
        check("rf_old", 32'(bus.t1_doutD), 32'd0);
        step();
        check("rf_new", 32'(bus.t1_doutE), 32'h1234);

        // back-to-back pipelined reads
        wr(0, 1, 16'h0011, 16'hFFFF); step(); idle();
        wr(0, 2, 16'h0022, 16'hFFFF); step(); idle();
        wr(0, 3, 16'h0033, 16'hFFFF); step(); idle();
        rd(0, 1); step();
        rd(0, 2); step();
        check("pipe0", 32'(bus.t1_doutD), 32'h11);
        rd(0, 3); step();
        idle();
        check("pipe1", 32'(bus.t1_doutD), 32'h22);
        step();
        check("pipe2", 32'(bus.t1_doutD), 32'h33);
        check("pipe2_vld", 32'(bus.t1_vldD), 32'd1);
        step();
        check("pipe_end_vld", 32'(bus.t1_vldD), 32'd0);
        check("pipe_hold", 32'(bus.t1_doutD), 32'h33);
        check("err_clean", 32'(err), 32'd0);

        // out-of-range write is dropped and flags err; out-of-range read returns 0
        wr(0, 1030, 16'hBEEF, 16'hFFFF);
        step();
        idle();
        check("oor_wr_err", 32'(err), 32'd1);
        rd(0, 1030);
        rd(1, 6);
        step();
        idle();
        step();
        check("oor_rd_vld", 32'(bus.t1_vldD), 32'd1);
        check("oor_rd_data", 32'(bus.t1_doutD), 32'd0);
        check("oor_no_alias", 32'(bus.t1_doutE), 32'd0);

        // reset while a read is in flight: result dropped, fill restarts
        rd(1, 3);
        step();
        idle();
        rst = 1'b0;
        step();
        check("mrr_vld", 32'(bus.t1_vldE), 32'd0);
        check("mrr_done", 32'(init_done), 32'd0);
        step();
        check("mrr_vld2", 32'(bus.t1_vldE), 32'd0);
        rst = 1'b1;
        wait_init(0);
        rd(0, 7);
        step();
        idle();
        step();
        check("refill", 32'(bus.t1_doutD), 32'd0);

        // random traffic on a small address window with occasional out-of-range accesses
        for (int c = 0; c < 3000; c++) begin
            idle();
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 1) == 1) wr(p, rand_addr(), W'($urandom), W'($urandom));
            end
            for (int r = 0; r < 2; r++) begin
                if ($urandom_range(0, 2) != 0) rd(r, rand_addr());
            end
            step();
        end
        idle();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
